// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared types and constants for the seq_gen serial pattern transmitter.
//   state_e   : transmitter FSM states (idle, shifting bits out, inter-repetition gap)
//   RepsW     : width of the repetition down-counter
//   GapW      : width of the gap length / gap down-counter
//   Prbs7Seed : LFSR value after reset for the optional gap filler
//   Prbs7Taps : feedback taps for x^7 + x^6 + 1
package seq_gen_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } state_e;

    localparam int unsigned RepsW = 8;
    localparam int unsigned GapW  = 4;

    localparam logic [6:0] Prbs7Seed = 7'h7F;
    localparam logic [6:0] Prbs7Taps = 7'b110_0000;

endpackage

// File: rtl/seq_gen_prbs7.sv
// seq_gen_prbs7: Fibonacci PRBS7 generator (x^7 + x^6 + 1) used as gap filler.
//   clk  : clock
//   rst  : synchronous active-high reset, loads Prbs7Seed
//   adv  : advance the LFSR by one step on this edge
//   prbs : current output bit (LFSR MSB)
module seq_gen_prbs7
    import seq_gen_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic adv,
    output logic prbs
);

    logic [6:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= Prbs7Seed;
        end else if (adv) begin
            lfsr_q <= {lfsr_q[5:0], ^(lfsr_q & Prbs7Taps)};
        end
    end

    assign prbs = lfsr_q[6];

endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial test-pattern transmitter. Shifts a right-aligned pattern out MSB-first
// (bit len-1 first), reps+1 times, with gap idle cycles between repetitions.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   start   : request a transmission (sampled only while idle)
//   pattern : pattern bits, right-aligned
//   len     : bits per transmission, 1..W (other values ignore start)
//   reps    : extra repetitions
//   gap     : idle cycles between repetitions
//   x       : serial data out
//   x_vld   : x carries a pattern bit
//   busy    : sequence in progress
//   done    : one-cycle pulse after the final bit
// Build option SEQ_GEN_PRBS_EN: drive PRBS7 filler on x during gap cycles.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W-1:0]         pattern,
    input  logic [$clog2(W):0]   len,
    input  logic [RepsW-1:0]     reps,
    input  logic [GapW-1:0]      gap,
    output logic                 x,
    output logic                 x_vld,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned LenW = $clog2(W) + 1;

    state_e            state_q;
    logic [W-1:0]      sreg_q;
    logic [W-1:0]      pat_q;
    logic [LenW-1:0]   len_q;
    logic [LenW-1:0]   bit_cnt_q;
    logic [RepsW-1:0]  reps_cnt_q;
    logic [GapW-1:0]   gap_q;
    logic [GapW-1:0]   gap_cnt_q;
    logic              x_q;
    logic              x_vld_q;
    logic              busy_q;
    logic              done_q;

    logic              len_ok;
    logic [W-1:0]      start_word;
    logic [W-1:0]      reload_word;
    logic              fill_bit;

    // Left-justify the pattern so the first bit to send sits in the MSB.
    function automatic logic [W-1:0] align(logic [W-1:0] p, logic [LenW-1:0] l);
        return p << (W - 32'(l));
    endfunction

    assign len_ok      = start && (len != '0) && (32'(len) <= W);
    assign start_word  = align(pattern, len);
    assign reload_word = align(pat_q, len_q);

`ifdef SEQ_GEN_PRBS_EN
    logic fill_adv;
    logic prbs_bit;

    // Advance exactly when a filler bit is loaded into x for a gap cycle.
    assign fill_adv = (state_q == StSend && bit_cnt_q == '0 && reps_cnt_q != '0 &&
                       gap_q != '0) ||
                      (state_q == StGap && gap_cnt_q != '0);

    seq_gen_prbs7 u_prbs (
        .clk  (clk),
        .rst  (rst),
        .adv  (fill_adv),
        .prbs (prbs_bit)
    );

    assign fill_bit = prbs_bit;
`else
    assign fill_bit = 1'b0;
`endif

    // Outputs are registered; bit_cnt_q holds the bits still to send after the one on x.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sreg_q     <= '0;
            pat_q      <= '0;
            len_q      <= '0;
            bit_cnt_q  <= '0;
            reps_cnt_q <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            x_q        <= 1'b0;
            x_vld_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (len_ok) begin
                        pat_q      <= pattern;
                        len_q      <= len;
                        reps_cnt_q <= reps;
                        gap_q      <= gap;
                        x_q        <= start_word[W-1];
                        sreg_q     <= start_word << 1;
                        bit_cnt_q  <= len - 1'b1;
                        x_vld_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    if (bit_cnt_q != '0) begin
                        x_q       <= sreg_q[W-1];
                        sreg_q    <= sreg_q << 1;
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end else if (reps_cnt_q != '0) begin
                        reps_cnt_q <= reps_cnt_q - 1'b1;
                        if (gap_q == '0) begin
                            // Back-to-back repetition, no bubble.
                            x_q       <= reload_word[W-1];
                            sreg_q    <= reload_word << 1;
                            bit_cnt_q <= len_q - 1'b1;
                        end else begin
                            state_q   <= StGap;
                            gap_cnt_q <= gap_q - 1'b1;
                            x_q       <= fill_bit;
                            x_vld_q   <= 1'b0;
                        end
                    end else begin
                        state_q <= StIdle;
                        x_q     <= 1'b0;
                        x_vld_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StGap: begin
                    if (gap_cnt_q != '0) begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                        x_q       <= fill_bit;
                    end else begin
                        state_q   <= StSend;
                        x_q       <= reload_word[W-1];
                        sreg_q    <= reload_word << 1;
                        bit_cnt_q <= len_q - 1'b1;
                        x_vld_q   <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign x     = x_q;
    assign x_vld = x_vld_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: randomized and directed bench for seq_gen against a queue-based model.
// The model expands each accepted request into the full list of future output cycles.
module tb_seq_gen;

    localparam int unsigned W    = 8;
    localparam int unsigned LenW = $clog2(W) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [W-1:0]    pattern;
    logic [LenW-1:0] len;
    logic [7:0]      reps;
    logic [3:0]      gap;
    logic            x;
    logic            x_vld;
    logic            busy;
    logic            done;

    seq_gen #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .gap     (gap),
        .x       (x),
        .x_vld   (x_vld),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic x;
        logic vld;
    } ent_t;

    ent_t  q[$];
    logic  m_x, m_vld, m_busy, m_done;

    int    checks = 0;
    int    errors = 0;

    logic [63:0] cap_bits;
    int          cap_n, busy_n, done_n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference behaviour at one rising edge, using the inputs currently applied.
    task automatic model_edge();
        ent_t e;
        if (rst) begin
            q.delete();
            {m_x, m_vld, m_busy, m_done} = 4'b0;
        end else if (m_busy) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                m_x = e.x; m_vld = e.vld; m_busy = 1'b1; m_done = 1'b0;
            end else begin
                m_x = 1'b0; m_vld = 1'b0; m_busy = 1'b0; m_done = 1'b1;
            end
        end else if (start && len >= 1 && 32'(len) <= W) begin
            for (int r = 0; r <= int'(reps); r++) begin
                for (int i = int'(len) - 1; i >= 0; i--) q.push_back('{pattern[i], 1'b1});
                if (r < int'(reps))
                    for (int g = 0; g < int'(gap); g++) q.push_back('{1'b0, 1'b0});
            end
            e = q.pop_front();
            m_x = e.x; m_vld = e.vld; m_busy = 1'b1; m_done = 1'b0;
        end else begin
            {m_x, m_vld, m_busy, m_done} = 4'b0;
        end
    endtask

    // One clock: model steps with the DUT, outputs compared mid-cycle.
    task automatic cycle();
        logic x_care;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        x_care = 1'b1;
`ifdef SEQ_GEN_PRBS_EN
        x_care = !(m_busy && !m_vld);
`endif
        if (x_care) check("x", 64'(x), 64'(m_x));
        check("x_vld", 64'(x_vld), 64'(m_vld));
        check("busy", 64'(busy), 64'(m_busy));
        check("done", 64'(done), 64'(m_done));
        if (x_vld === 1'b1) begin
            cap_bits = {cap_bits[62:0], x};
            cap_n++;
        end
        if (busy === 1'b1) busy_n++;
        if (done === 1'b1) done_n++;
    endtask

    task automatic clear_cap();
        cap_bits = '0; cap_n = 0; busy_n = 0; done_n = 0;
    endtask

    // Pulse start for one cycle, then scramble the inputs and wait for done.
    task automatic run_txn(input logic [W-1:0] p, input int l, input int rp, input int gp,
                           output int cyc);
        int n;
        pattern = p; len = LenW'(l); reps = 8'(rp); gap = 4'(gp);
        start = 1'b1;
        clear_cap();
        cycle();
        start = 1'b0;
        pattern = W'($urandom); len = LenW'($urandom); reps = 8'($urandom); gap = 4'($urandom);
        n = 1;
        while (done !== 1'b1 && n < 2000) begin
            cycle();
            n++;
        end
        check("txn_timeout", 64'(n < 2000), 64'(1));
        cyc = n;
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; pattern = '0; len = '0; reps = '0; gap = '0;
        m_x = 1'b0; m_vld = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        clear_cap();
        cycle();
        cycle();
        check("reset_outs", 64'({x, x_vld, busy, done}), 64'(0));
        rst = 1'b0;
        cycle();

        // Single 4-bit transmission.
        run_txn(8'h0B, 4, 0, 0, cyc);
        check("t1_bits", cap_bits & 64'hF, 64'hB);
        check("t1_nbits", 64'(cap_n), 64'(4));
        check("t1_busy", 64'(busy_n), 64'(4));
        check("t1_done_cycle", 64'(cyc), 64'(5));
        check("t1_done_n", 64'(done_n), 64'(1));

        // Three back-to-back repetitions.
        run_txn(8'h0B, 4, 2, 0, cyc);
        check("t2_bits", cap_bits & 64'hFFF, 64'hBBB);
        check("t2_busy", 64'(busy_n), 64'(12));
        check("t2_nbits", 64'(cap_n), 64'(12));
        check("t2_done_n", 64'(done_n), 64'(1));

        // Repetition with a 2-cycle gap.
        run_txn(8'h05, 3, 1, 2, cyc);
        check("t3_bits", cap_bits & 64'h3F, 64'h2D);
        check("t3_busy", 64'(busy_n), 64'(8));
        check("t3_nbits", 64'(cap_n), 64'(6));

        // start during busy is ignored; start with done is accepted.
        clear_cap();
        pattern = 8'h0B; len = 4; reps = 0; gap = 0; start = 1'b1;
        cycle();
        start = 1'b0; pattern = 8'hFF;
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int n = 0; n < 20 && done !== 1'b1; n++) cycle();
        check("t4_done_seen", 64'(done), 64'(1));
        check("t4_bits", cap_bits & 64'hF, 64'hB);
        check("t4_nbits", 64'(cap_n), 64'(4));
        clear_cap();
        pattern = 8'h05; len = 3; start = 1'b1;
        cycle();
        start = 1'b0;
        check("t4_restart", 64'({x, x_vld, busy}), 64'(3'b111));
        for (int n = 0; n < 20 && done !== 1'b1; n++) cycle();
        check("t4_bits2", cap_bits & 64'h7, 64'h5);
        check("t4_nbits2", 64'(cap_n), 64'(3));

        // Reset mid-transmission, then a full len=W pattern.
        pattern = 8'hA5; len = 8; reps = 0; gap = 0; start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        clear_cap();
        cycle();
        check("t5_rst_outs", 64'({x, x_vld, busy, done}), 64'(0));
        rst = 1'b0;
        for (int n = 0; n < 12; n++) cycle();
        check("t5_no_done", 64'(done_n), 64'(0));
        run_txn(8'hA5, 8, 0, 0, cyc);
        check("t5_bits", cap_bits & 64'hFF, 64'hA5);
        check("t5_nbits", 64'(cap_n), 64'(8));

        // Invalid lengths are ignored.
        clear_cap();
        pattern = 8'hFF; len = 0; start = 1'b1;
        cycle();
        len = 9;
        cycle();
        len = 15;
        cycle();
        start = 1'b0;
        for (int n = 0; n < 5; n++) cycle();
        check("t6_busy_n", 64'(busy_n), 64'(0));
        check("t6_done_n", 64'(done_n), 64'(0));

        // Random traffic including scrambled inputs while busy and sporadic resets.
        for (int n = 0; n < 4000; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            start   = ($urandom_range(0, 3) == 0);
            pattern = W'($urandom);
            len     = LenW'($urandom_range(0, 10));
            reps    = 8'($urandom_range(0, 3));
            gap     = 4'($urandom_range(0, 3));
            cycle();
        end
        rst = 1'b0; start = 1'b0;
        for (int n = 0; n < 80; n++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
